// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular write FIFO.
// Frames are drained automatically and sent back-to-back while bytes remain queued.
module uart_tx_fifo #(
   parameter int BAUD_DIV = 2604,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       TX,
   output logic       busy,
   output logic       tx_done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count, count_n;
   logic             wr_ok, pop, bit_last, tx_n, stop_end, stop_end_q;

   // full is the registered flag, so a write in the same cycle as a pop is still refused
   assign wr_ok    = wr_en && !full;
   assign bit_last = (baud_cnt == CNT_W'(BAUD_DIV - 1));
   assign stop_end = (state == STOP) && bit_last;
   assign count_n  = count + (AW+1)'(wr_ok) - (AW+1)'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && full)
            overflow <= 1'b1;
         count <= count_n;
         full  <= (count_n == (AW+1)'(DEPTH));
         empty <= (count_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
      end
   end

   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      pop        = 1'b0;
      tx_n       = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_n    = mem[rd_ptr];
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = START;
            end
         end
         START: begin
            tx_n = 1'b0;
            if (bit_last) begin
               baud_cnt_n = '0;
               state_n    = DATA;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            tx_n = shift[0];
            if (bit_last) begin
               baud_cnt_n = '0;
               shift_n    = {1'b0, shift[7:1]};
               bit_idx_n  = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_n = STOP;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            tx_n = 1'b1;
            if (bit_last) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               // Chain straight into the next start bit when more bytes wait
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line outputs trail the state by one clock; tx_done lands on the edge that ends the stop bit
   always_ff @(posedge clk) begin
      if (rst) begin
         TX         <= 1'b1;
         busy       <= 1'b0;
         stop_end_q <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         TX         <= tx_n;
         busy       <= (state != IDLE);
         stop_end_q <= stop_end;
         tx_done    <= stop_end_q;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4, DEPTH=4 with a line-level receiver model.
module tb_uart_tx_fifo;

   localparam int BD = 4;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, overflow, TX, busy, tx_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rst_cnt = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   uart_tx_fifo #(.BAUD_DIV(BD), .DEPTH(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .overflow(overflow),
      .TX(TX), .busy(busy), .tx_done(tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) rst_cnt <= rst_cnt + 1;
   end

   always @(negedge clk)
      if (tx_done === 1'b1) done_cnt = done_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
      wr_data = ~d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      repeat (3) @(negedge clk);
      while ((busy !== 1'b0 || empty !== 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_timeout"}, 32'(n < limit), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   // Receiver model: samples mid-bit, discards frames cut short by reset
   initial begin : rx_monitor
      logic [7:0]  b;
      logic [31:0] e;
      int st, r0;
      forever begin
         @(negedge clk);
         if (TX === 1'b0) begin
            st = cyc;
            r0 = rst_cnt;
            b  = '0;
            repeat (BD/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = TX;
            end
            repeat (BD) @(negedge clk);
            if (rst_cnt == r0) begin
               check_eq("rx_stop", 32'(TX), 32'd1);
               start_q.push_back(st);
               e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h1FF;
               check_eq("rx_byte", 32'(b), e);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [9:0] t1_pat;
      int d0;
      t1_pat  = 10'b1_10100101_0;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;

      // reset state
      repeat (2) @(negedge clk);
      check_eq("rst_tx", 32'(TX), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      check_eq("rst_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // test 1: single byte A5, exact line waveform and latency
      d0 = done_cnt;
      exp_q.push_back(8'hA5);
      wr(8'hA5);
      check_eq("t1_empty", 32'(empty), 32'd0);
      check_eq("t1_tx_n0", 32'(TX), 32'd1);
      @(negedge clk);
      check_eq("t1_tx_n1", 32'(TX), 32'd1);
      check_eq("t1_busy_n1", 32'(busy), 32'd0);
      @(negedge clk);
      for (int j = 0; j < 40; j++) begin
         check_eq("t1_bit", 32'(TX), 32'(t1_pat[j/4]));
         check_eq("t1_nodone", 32'(tx_done), 32'd0);
         if (j == 0) check_eq("t1_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      check_eq("t1_done", 32'(tx_done), 32'd1);
      check_eq("t1_busy_end", 32'(busy), 32'd0);
      check_eq("t1_empty_end", 32'(empty), 32'd1);
      @(negedge clk);
      check_eq("t1_done_pulse", 32'(tx_done), 32'd0);
      wait_idle("t1", 200);
      check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

      // test 2: three back-to-back frames
      start_q.delete();
      d0 = done_cnt;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hAC);
      wr(8'hFF);
      wr(8'h00);
      wr(8'hAC);
      wait_idle("t2", 400);
      check_eq("t2_done_cnt", 32'(done_cnt - d0), 32'd3);
      check_eq("t2_frames", 32'(start_q.size()), 32'd3);
      if (start_q.size() == 3) begin
         check_eq("t2_gap1", 32'(start_q[1] - start_q[0]), 32'd40);
         check_eq("t2_gap2", 32'(start_q[2] - start_q[1]), 32'd40);
      end
      check_eq("t2_drained", 32'(exp_q.size()), 32'd0);

      // test 3: six writes, fifth fills the FIFO, sixth overflows
      d0 = done_cnt;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      exp_q.push_back(8'h55);
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wr(8'h44);
      wr(8'h55);
      check_eq("t3_full5", 32'(full), 32'd1);
      check_eq("t3_noovf5", 32'(overflow), 32'd0);
      wr(8'h66);
      check_eq("t3_full6", 32'(full), 32'd1);
      check_eq("t3_ovf6", 32'(overflow), 32'd1);
      wait_idle("t3", 800);
      check_eq("t3_done_cnt", 32'(done_cnt - d0), 32'd5);
      check_eq("t3_drained", 32'(exp_q.size()), 32'd0);
      check_eq("t3_ovf_sticky", 32'(overflow), 32'd1);

      // test 4: write while full on the cycle of the stop-end pop
      do_reset();
      @(negedge clk);
      check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
      d0 = done_cnt;
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hA2);
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'hA4);
      exp_q.push_back(8'hA5);
      wr(8'hA1);
      wr(8'hA2);
      wr(8'hA3);
      wr(8'hA4);
      wr(8'hA5);
      check_eq("t4_full", 32'(full), 32'd1);
      repeat (36) @(negedge clk);
      check_eq("t4_prepop_full", 32'(full), 32'd1);
      check_eq("t4_prepop_ovf", 32'(overflow), 32'd0);
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("t4_ovf", 32'(overflow), 32'd1);
      check_eq("t4_full_after", 32'(full), 32'd0);
      check_eq("t4_empty_after", 32'(empty), 32'd0);
      @(negedge clk);
      check_eq("t4_done", 32'(tx_done), 32'd1);
      wait_idle("t4", 800);
      check_eq("t4_done_cnt", 32'(done_cnt - d0), 32'd5);
      check_eq("t4_drained", 32'(exp_q.size()), 32'd0);

      // test 5: reset during data bit 3 of 3C, queue full and overflowed
      wr(8'h3C);
      wr(8'hB1);
      wr(8'hB2);
      wr(8'hB3);
      wr(8'hB4);
      wr(8'hB5);
      repeat (14) @(negedge clk);
      check_eq("t5_pre_ovf", 32'(overflow), 32'd1);
      check_eq("t5_pre_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("t5_tx", 32'(TX), 32'd1);
      check_eq("t5_busy", 32'(busy), 32'd0);
      check_eq("t5_empty", 32'(empty), 32'd1);
      check_eq("t5_full", 32'(full), 32'd0);
      check_eq("t5_ovf", 32'(overflow), 32'd0);
      check_eq("t5_done", 32'(tx_done), 32'd0);
      d0 = done_cnt;
      repeat (45) @(negedge clk);
      check_eq("t5_quiet_done", 32'(done_cnt - d0), 32'd0);
      check_eq("t5_quiet_tx", 32'(TX), 32'd1);
      exp_q.push_back(8'h5A);
      wr(8'h5A);
      wait_idle("t5", 200);
      check_eq("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_eq("t5_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
